// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
//   Command-side driver for a bit-plane operand stack built from WIDTH
//   single-bit shift-register stacks of DEPTH entries that all share one mode.
//   Calculator ops arrive over a valid/ready handshake. Each op is checked
//   against the tracked stack depth. A legal op drives one stack mode plus a
//   WIDTH-bit word (bit i goes to plane i) for exactly one cycle. ADD, SUB and
//   NOT results are formed from TOS/NOS as read back from the planes.
//
// Ports
//   clk       in   1        single clock; everything updates on posedge
//   reset     in   1        synchronous, active-high
//   op        in   4        opcode
//   op_data   in   WIDTH    literal for PUSH
//   op_valid  in   1        op/op_data valid
//   op_ready  out  1        sequencer can accept (IDLE or ERR)
//   tos       in   WIDTH    stack entry 0 read back from the planes
//   nos       in   WIDTH    stack entry 1 read back from the planes
//   mode      out  3        stack mode to all planes
//   d         out  WIDTH    per-plane d bit
//   depth     out  clog2(DEPTH+1)  number of valid entries, 0..DEPTH
//   err       out  1        sticky error flag
//   err_code  out  2        1=underflow, 2=overflow, 3=illegal op, 0 when !err
// -----------------------------------------------------------------------------
module stack_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] tos,
    input  logic [WIDTH-1:0] nos,
    output logic [2:0]       mode,
    output logic [WIDTH-1:0] d,
    output logic [DW-1:0]    depth,
    output logic             err,
    output logic [1:0]       err_code
);

    // Stack mode encoding shared with the bit-plane stacks.
    localparam logic [2:0] STACK_MODE_IDLE  = 3'd0;
    localparam logic [2:0] STACK_MODE_RESET = 3'd1;
    localparam logic [2:0] STACK_MODE_PUSH  = 3'd2;
    localparam logic [2:0] STACK_MODE_POP   = 3'd3;
    localparam logic [2:0] STACK_MODE_SWAP  = 3'd4;
    localparam logic [2:0] STACK_MODE_ROLL  = 3'd5;
    localparam logic [2:0] STACK_MODE_ROLL2 = 3'd6;
    localparam logic [2:0] STACK_MODE_POP2  = 3'd7;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSH  = 4'd1;
    localparam logic [3:0] OP_POP   = 4'd2;
    localparam logic [3:0] OP_SWAP  = 4'd3;
    localparam logic [3:0] OP_DUP   = 4'd4;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_NOT   = 4'd7;
    localparam logic [3:0] OP_DROP2 = 4'd8;
    localparam logic [3:0] OP_CLEAR = 4'd9;

    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
    localparam logic [DW-1:0] ONE        = DW'(1);
    localparam logic [DW-1:0] TWO        = DW'(2);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_EXEC = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t           state_reg,    state_next;
    logic [2:0]       mode_reg,     mode_next;
    logic [WIDTH-1:0] d_reg,        d_next;
    logic [DW-1:0]    depth_reg,    depth_next;
    logic             err_reg,      err_next;
    logic [1:0]       err_code_reg, err_code_next;

    // Decoded view of the current op against the current depth.
    logic [2:0]       dec_mode;
    logic [WIDTH-1:0] dec_d;
    logic [DW-1:0]    dec_depth;
    logic             dec_underflow;
    logic             dec_overflow;
    logic             dec_illegal;
    logic             dec_fail;
    logic [1:0]       dec_code;

    logic             accept;
    logic             has_one;
    logic             has_two;
    logic             is_full;
    logic [WIDTH-1:0] not_tos;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_not
            assign not_tos[gi] = ~tos[gi];
        end
    endgenerate

    assign op_ready = (state_reg == ST_IDLE) || (state_reg == ST_ERR);
    assign accept   = op_valid && op_ready;
    assign has_one  = (depth_reg >= ONE);
    assign has_two  = (depth_reg >= TWO);
    assign is_full  = (depth_reg == DEPTH_FULL);

    always_comb begin
        dec_mode      = STACK_MODE_IDLE;
        dec_d         = '0;
        dec_depth     = depth_reg;
        dec_underflow = 1'b0;
        dec_overflow  = 1'b0;
        dec_illegal   = 1'b0;
        unique case (op)
            OP_NOP: begin
            end
            OP_PUSH: begin
                dec_overflow = is_full;
                dec_mode     = STACK_MODE_PUSH;
                dec_d        = op_data;
                dec_depth    = depth_reg + ONE;
            end
            OP_POP: begin
                dec_underflow = !has_one;
                dec_mode      = STACK_MODE_POP;
                dec_depth     = depth_reg - ONE;
            end
            OP_SWAP: begin
                dec_underflow = !has_two;
                dec_mode      = STACK_MODE_SWAP;
            end
            OP_DUP: begin
                dec_underflow = !has_one;
                dec_overflow  = is_full;
                dec_mode      = STACK_MODE_PUSH;
                dec_d         = tos;
                dec_depth     = depth_reg + ONE;
            end
            OP_ADD: begin
                dec_underflow = !has_two;
                dec_mode      = STACK_MODE_ROLL2;
                dec_d         = nos + tos;
                dec_depth     = depth_reg - ONE;
            end
            OP_SUB: begin
                dec_underflow = !has_two;
                dec_mode      = STACK_MODE_ROLL2;
                dec_d         = nos - tos;
                dec_depth     = depth_reg - ONE;
            end
            OP_NOT: begin
                dec_underflow = !has_one;
                dec_mode      = STACK_MODE_ROLL;
                dec_d         = not_tos;
            end
            OP_DROP2: begin
                dec_underflow = !has_two;
                dec_mode      = STACK_MODE_POP2;
                dec_depth     = depth_reg - TWO;
            end
            OP_CLEAR: begin
                dec_mode  = STACK_MODE_RESET;
                dec_depth = '0;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Underflow takes priority over overflow (DUP can trip either).
    assign dec_fail = dec_underflow || dec_overflow || dec_illegal;
    assign dec_code = dec_underflow ? ERR_UNDERFLOW :
                      dec_overflow  ? ERR_OVERFLOW  :
                      dec_illegal   ? ERR_ILLEGAL   : 2'd0;

    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        d_next        = d_reg;
        depth_next    = depth_reg;
        err_next      = err_reg;
        err_code_next = err_code_reg;
        unique case (state_reg)
            ST_INIT: begin
                mode_next  = STACK_MODE_IDLE;
                d_next     = '0;
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    if (dec_fail) begin
                        // Op is consumed but nothing reaches the planes.
                        err_next      = 1'b1;
                        err_code_next = dec_code;
                        state_next    = ST_ERR;
                    end else begin
                        mode_next  = dec_mode;
                        d_next     = dec_d;
                        depth_next = dec_depth;
                        state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                mode_next  = STACK_MODE_IDLE;
                d_next     = '0;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                // Only CLEAR escapes; every other op is swallowed.
                if (accept && (op == OP_CLEAR)) begin
                    mode_next     = STACK_MODE_RESET;
                    d_next        = '0;
                    depth_next    = '0;
                    err_next      = 1'b0;
                    err_code_next = 2'd0;
                    state_next    = ST_EXEC;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
        if (accept && (state_reg == ST_IDLE) && (op == OP_CLEAR)) begin
            err_next      = 1'b0;
            err_code_next = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_INIT;
            mode_reg     <= STACK_MODE_RESET;
            d_reg        <= '0;
            depth_reg    <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            d_reg        <= d_next;
            depth_reg    <= depth_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
        end
    end

    assign mode     = mode_reg;
    assign d        = d_reg;
    assign depth    = depth_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_RESET = 3'd1;
    localparam logic [2:0] M_PUSH  = 3'd2;
    localparam logic [2:0] M_POP   = 3'd3;
    localparam logic [2:0] M_SWAP  = 3'd4;
    localparam logic [2:0] M_ROLL  = 3'd5;
    localparam logic [2:0] M_ROLL2 = 3'd6;
    localparam logic [2:0] M_POP2  = 3'd7;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       op;
    logic [WIDTH-1:0] op_data;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [DW-1:0]    depth;
    logic             err;
    logic [1:0]       err_code;

    always #5 clk = ~clk;

    stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .op_data  (op_data),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .tos      (tos),
        .nos      (nos),
        .mode     (mode),
        .d        (d),
        .depth    (depth),
        .err      (err),
        .err_code (err_code)
    );

    // Behavioural bit-plane stack: consumes mode/d at each clock edge.
    logic [WIDTH-1:0] stk [0:DEPTH-1];
    assign tos = stk[0];
    assign nos = stk[1];

    typedef struct packed {
        logic [2:0]       mode;
        logic [WIDTH-1:0] d;
        logic [DW-1:0]    depth;
        logic             err;
        logic [1:0]       code;
    } exp_t;

    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state of the sequencer.
    int         m_depth;
    logic       m_err;
    logic [1:0] m_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic predict(input logic [3:0] o, input logic [WIDTH-1:0] dat, output exp_t e);
        logic [2:0]       md;
        logic [WIDTH-1:0] dd;
        int               nd;
        bit               unf, ovf, ill;
        md = M_IDLE; dd = '0; nd = m_depth; unf = 0; ovf = 0; ill = 0;
        case (o)
            4'd0: ;
            4'd1: begin ovf = (m_depth >= DEPTH); md = M_PUSH; dd = dat; nd = m_depth + 1; end
            4'd2: begin unf = (m_depth < 1); md = M_POP; nd = m_depth - 1; end
            4'd3: begin unf = (m_depth < 2); md = M_SWAP; end
            4'd4: begin unf = (m_depth < 1); ovf = (m_depth >= DEPTH); md = M_PUSH; dd = tos; nd = m_depth + 1; end
            4'd5: begin unf = (m_depth < 2); md = M_ROLL2; dd = nos + tos; nd = m_depth - 1; end
            4'd6: begin unf = (m_depth < 2); md = M_ROLL2; dd = nos - tos; nd = m_depth - 1; end
            4'd7: begin unf = (m_depth < 1); md = M_ROLL; dd = ~tos; end
            4'd8: begin unf = (m_depth < 2); md = M_POP2; nd = m_depth - 2; end
            4'd9: begin md = M_RESET; nd = 0; end
            default: ill = 1;
        endcase
        if (m_err && o != 4'd9) begin
            e = '{M_IDLE, '0, DW'(m_depth), 1'b1, m_code};
        end else if (unf || ovf || ill) begin
            m_err  = 1'b1;
            m_code = unf ? 2'd1 : (ovf ? 2'd2 : 2'd3);
            e = '{M_IDLE, '0, DW'(m_depth), 1'b1, m_code};
        end else begin
            m_depth = nd;
            if (o == 4'd9) begin
                m_err  = 1'b0;
                m_code = 2'd0;
            end
            e = '{md, dd, DW'(m_depth), m_err, m_code};
        end
    endtask

    task automatic do_op(input logic [3:0] o, input logic [WIDTH-1:0] dat);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            check("ready_timeout", 32'(op_ready), 32'd1);
            return;
        end
        op      = o;
        op_data = dat;
        predict(o, dat, e);
        sbq.push_back(e);
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Plane model and scoreboard consumer.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else begin
            case (mode)
                M_RESET: for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
                M_PUSH: begin
                    stk[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
                end
                M_POP: begin
                    for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                    stk[DEPTH-1] <= '0;
                end
                M_SWAP: begin
                    stk[0] <= stk[1];
                    stk[1] <= stk[0];
                end
                M_ROLL: stk[0] <= d;
                M_ROLL2: begin
                    stk[0] <= d;
                    for (int i = 1; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                    stk[DEPTH-1] <= '0;
                end
                M_POP2: begin
                    for (int i = 0; i < DEPTH - 2; i++) stk[i] <= stk[i+2];
                    stk[DEPTH-2] <= '0;
                    stk[DEPTH-1] <= '0;
                end
                default: ;
            endcase
        end
        if (op_valid && op_ready && !reset) begin
            #1;
            if (sbq.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                $display("op %0d: mode=%0d d=%02h depth=%0d err=%0b code=%0d", op, mode, d, depth, err, err_code);
                check("sb_mode",  32'(mode),     32'(sbq[0].mode));
                check("sb_d",     32'(d),        32'(sbq[0].d));
                check("sb_depth", 32'(depth),    32'(sbq[0].depth));
                check("sb_err",   32'(err),      32'(sbq[0].err));
                check("sb_code",  32'(err_code), 32'(sbq[0].code));
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = '0; op_data = '0;
        m_depth = 0; m_err = 1'b0; m_code = 2'd0;

        // Reset held two cycles.
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_mode",  32'(mode),     32'(M_RESET));
            check("rst_depth", 32'(depth),    32'd0);
            check("rst_err",   32'(err),      32'd0);
            check("rst_ready", 32'(op_ready), 32'd0);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("init_mode",  32'(mode),     32'(M_IDLE));
        check("init_ready", 32'(op_ready), 32'd1);
        check("init_code",  32'(err_code), 32'd0);

        // ADD
        do_op(4'd1, 8'd5); do_op(4'd1, 8'd3); do_op(4'd5, 8'd0);
        settle();
        check("add_tos", 32'(tos), 32'd8);
        check("add_depth", 32'(depth), 32'd1);
        do_op(4'd2, 8'd0);

        // SUB
        do_op(4'd1, 8'd3); do_op(4'd1, 8'd5); do_op(4'd6, 8'd0);
        settle();
        check("sub_tos", 32'(tos), 32'hFE);
        do_op(4'd2, 8'd0);

        // SWAP / DUP / NOT / ADD / DROP2
        do_op(4'd1, 8'h11); do_op(4'd1, 8'h22); do_op(4'd3, 8'd0);
        do_op(4'd4, 8'd0); do_op(4'd7, 8'd0); do_op(4'd5, 8'd0);
        settle();
        check("mix_tos", 32'(tos), 32'hFF);
        check("mix_nos", 32'(nos), 32'h22);
        do_op(4'd8, 8'd0);

        // Fill to capacity, overflow, ignored POP, CLEAR
        for (int i = 1; i <= DEPTH; i++) do_op(4'd1, 8'(i));
        do_op(4'd1, 8'd9);
        do_op(4'd2, 8'd0);
        do_op(4'd9, 8'd0);
        settle();
        check("clr_tos", 32'(tos), 32'd0);

        // Underflow, then illegal op
        do_op(4'd2, 8'd0);
        do_op(4'd9, 8'd0);
        do_op(4'd12, 8'd0);
        do_op(4'd9, 8'd0);

        // op_valid held: op_ready alternates, one PUSH per two cycles
        begin
            int n;
            exp_t e;
            n = 0;
            @(negedge clk);
            while (!op_ready && n < 20) begin @(negedge clk); n++; end
            op = 4'd1; op_data = 8'h5A; op_valid = 1'b1;
            for (int k = 0; k < 8; k++) begin
                check("hold_ready", 32'(op_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
                if (op_ready) begin
                    predict(op, op_data, e);
                    sbq.push_back(e);
                end
                @(negedge clk);
            end
            op_valid = 1'b0;
        end

        // Reset during EXEC of DUP
        do_op(4'd4, 8'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_mode",  32'(mode),  32'(M_RESET));
        check("abort_depth", 32'(depth), 32'd0);
        check("abort_err",   32'(err),   32'd0);
        m_depth = 0; m_err = 1'b0; m_code = 2'd0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", 32'(op_ready), 32'd1);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
